// File: rtl/gf_pow_seq.sv
// ----------------------------------------------------------------------------
// gf_pow_seq
//
// Sequential GF(2^WIDTH) exponentiation unit: p = a^e.
//
// The exponent is scanned from its top bit down (left-to-right
// square-and-multiply). Each clock performs exactly one field multiply. A
// single combinational multiplier is shared between the square step and the
// multiply step. Field width, reduction polynomial and exponent width are
// parameters.
//
// Optional build macro: GF_POW_CONST_TIME_EN
//   When defined, every exponent bit costs one square and one multiply. For a
//   zero bit, the multiply result goes to a dummy register. Latency is then
//   2*EXP_W+1 cycles for every operand. When undefined, the multiply is
//   skipped for zero bits and latency is EXP_W + popcount(e) + 1.
//
// Parameters
//   WIDTH  field degree; width of a and p
//   POLY   low WIDTH bits of the reduction polynomial (x^WIDTH is implicit)
//   EXP_W  exponent width
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request; accepted only while ready=1
//   a      in   base, sampled on accept
//   e      in   exponent, sampled on accept
//   ready  out  high in IDLE
//   busy   out  high from the cycle after accept through the DONE cycle
//   done   out  one-cycle pulse; p valid
//   p      out  result register; holds its value until the next done
//
// Handshake: a request is taken on a rising edge where start=1 and ready=1.
// A start seen while ready=0 (including the DONE cycle) is dropped, not
// queued. The inputs a and e are free to change after that edge.
// ----------------------------------------------------------------------------
module gf_pow_seq #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h63,
    parameter int               EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [EXP_W-1:0] e,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    // Bit-index width. It is kept at least one bit wide so that EXP_W=1
    // still elaborates.
    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IW-1:0]    I_TOP   = IW'(EXP_W - 1);
    localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQR  = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Field multiply: shift-and-add over the bits of y.
    // The running multiple of x is reduced each time it is shifted up.
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] s;
        r = '0;
        s = x;
        for (int k = 0; k < WIDTH; k++) begin
            if (y[k]) begin
                r = r ^ s;
            end
            if (s[WIDTH-1]) begin
                s = (s << 1) ^ POLY;
            end else begin
                s = s << 1;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [WIDTH-1:0] base_q,  base_d;
    logic [EXP_W-1:0] expo_q,  expo_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [WIDTH-1:0] p_q,     p_d;
    logic             ready_q, ready_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef GF_POW_CONST_TIME_EN
    logic [WIDTH-1:0] dummy_q, dummy_d;
`endif

    // Shared multiplier. In SQR it squares acc; otherwise it forms acc*base.
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_res;
    logic             cur_bit;
    logic             last_bit;

    assign mul_b    = (state_q == S_SQR) ? acc_q : base_q;
    assign mul_res  = gf_mul(acc_q, mul_b);
    assign cur_bit  = expo_q[idx_q];
    assign last_bit = (idx_q == '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        expo_d  = expo_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        p_d     = p_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef GF_POW_CONST_TIME_EN
        dummy_d = dummy_q;
`endif

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (start) begin
                    base_d  = a;
                    expo_d  = e;
                    acc_d   = ONE_VAL;
                    idx_d   = I_TOP;
                    state_d = S_SQR;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            S_SQR: begin
                // The first square runs on acc=1 and is kept on purpose.
                // That keeps the cycle count independent of leading zeros.
                acc_d = mul_res;
`ifdef GF_POW_CONST_TIME_EN
                state_d = S_MUL;
`else
                if (cur_bit) begin
                    state_d = S_MUL;
                end else if (last_bit) begin
                    state_d = S_DONE;
                    p_d     = mul_res;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
`endif
            end

            S_MUL: begin
`ifdef GF_POW_CONST_TIME_EN
                // A zero bit still spends a multiply. Its product lands in
                // dummy so the timing does not depend on the exponent.
                if (cur_bit) begin
                    acc_d = mul_res;
                end else begin
                    dummy_d = mul_res;
                end
                if (last_bit) begin
                    state_d = S_DONE;
                    p_d     = cur_bit ? mul_res : acc_q;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = S_SQR;
                end
`else
                acc_d = mul_res;
                if (last_bit) begin
                    state_d = S_DONE;
                    p_d     = mul_res;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = S_SQR;
                end
`endif
            end

            S_DONE: begin
                // A start in this cycle is dropped; re-accept opens next cycle.
                state_d = S_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            expo_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            p_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GF_POW_CONST_TIME_EN
            dummy_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            expo_q  <= expo_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            p_q     <= p_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GF_POW_CONST_TIME_EN
            dummy_q <= dummy_d;
`endif
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign p     = p_q;

endmodule

// File: tb/tb_gf_pow_seq.sv
// Testbench for gf_pow_seq with the default parameters: GF(2^8) and POLY 0x63.
module tb_gf_pow_seq;

    localparam int TIMEOUT = 100;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] e;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] p;

    always #5 clk = ~clk;

    gf_pow_seq #(
        .WIDTH (8),
        .POLY  (8'h63),
        .EXP_W (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .e     (e),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    // ---------------- scoreboard ----------------
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: full carry-less product, then reduction from the top.
    function automatic logic [7:0] m_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) prod = prod ^ (16'(x) << i);
        end
        for (int b = 15; b >= 8; b--) begin
            if (prod[b]) prod = prod ^ (16'h0163 << (b - 8));
        end
        return prod[7:0];
    endfunction

    // Right-to-left power, independent of the DUT's scan order.
    function automatic logic [7:0] m_pow(input logic [7:0] x, input logic [7:0] ex);
        logic [7:0] r;
        logic [7:0] b;
        r = 8'h01;
        b = x;
        for (int i = 0; i < 8; i++) begin
            if (ex[i]) r = m_mul(r, b);
            b = m_mul(b, b);
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [7:0] ex);
`ifdef GF_POW_CONST_TIME_EN
        return 17;
`else
        return 9 + $countones(ex);
`endif
    endfunction

    // ---------------- driver ----------------
    // Call at a negedge while the DUT is idle. Returns at the negedge of the
    // IDLE cycle that follows DONE.
    task automatic do_op(input logic [7:0] a_v, input logic [7:0] e_v,
                         output logic [7:0] p_v, output int lat);
        int busy_bad;
        busy_bad = 0;
        check("ready_before_start", int'(ready), 1);
        start = 1'b1;
        a     = a_v;
        e     = e_v;
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom_range(0, 255));
        e     = 8'($urandom_range(0, 255));
        lat   = 1;
        while (!done && lat < TIMEOUT) begin
            if (!busy || ready) busy_bad++;
            @(negedge clk);
            lat++;
        end
        check("done_seen", int'(done), 1);
        check("busy_window", busy_bad, 0);
        check("busy_in_done", int'({busy, ready}), 2);
        p_v = p;
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("p_holds", int'(p), int'(p_v));
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] e;
        logic [7:0] p;
    } vec_t;

    initial begin
        vec_t       vecs[9];
        logic [7:0] got;
        int         lat;
        int         done_cnt;
        logic [7:0] ra;
        logic [7:0] re;

        vecs[0] = '{8'h02, 8'h04, 8'h10};
        vecs[1] = '{8'h02, 8'h08, 8'h63};
        vecs[2] = '{8'h02, 8'h09, 8'hC6};
        vecs[3] = '{8'h03, 8'h02, 8'h05};
        vecs[4] = '{8'h02, 8'hFE, 8'hB1};
        vecs[5] = '{8'h57, 8'hFF, 8'h01};
        vecs[6] = '{8'h00, 8'h00, 8'h01};
        vecs[7] = '{8'h00, 8'h05, 8'h00};
        vecs[8] = '{8'hA5, 8'h01, 8'hA5};

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        e     = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_p", int'(p), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(ready), 1);

        // ---- table-driven directed vectors ----
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(vecs[i].p);
            do_op(vecs[i].a, vecs[i].e, got, lat);
            check($sformatf("vec%0d_p", i), int'(got), int'(exp_q.pop_front()));
            check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].e));
        end

        // ---- start while busy is ignored; start in DONE is ignored ----
        check("busy_seq_ready", int'(ready), 1);
        start = 1'b1;
        a     = 8'h02;
        e     = 8'h04;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (lat < 3) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b1;                       // cycle 3, while busy
        a     = 8'h03;
        e     = 8'hFF;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check("ignored_start_p", int'(p), 8'h10);
        check("ignored_start_lat", lat, exp_lat(8'h04));
        start = 1'b1;                       // pulse during the DONE cycle
        a     = 8'h03;
        e     = 8'h02;
        @(negedge clk);
        start = 1'b0;
        check("done_cycle_start_ready", int'(ready), 1);
        check("done_cycle_start_busy", int'(busy), 0);
        @(negedge clk);
        check("done_cycle_start_idle", int'({ready, busy}), 2);

        // ---- reset mid-operation ----
        done_cnt = 0;
        start = 1'b1;
        a     = 8'h02;
        e     = 8'hFE;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 5; c++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        rst = 1'b1;                         // cycle 5
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", int'(ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_p", int'(p), 0);
        for (int c = 0; c < 25; c++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("midrst_no_done", done_cnt, 0);

        // ---- random pairs against the software model ----
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            re = 8'($urandom_range(0, 255));
            exp_q.push_back(m_pow(ra, re));
            do_op(ra, re, got, lat);
            check($sformatf("rand_p a=%0h e=%0h", ra, re), int'(got), int'(exp_q.pop_front()));
            check($sformatf("rand_lat e=%0h", re), lat, exp_lat(re));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
